multiplier_shift_add: RTL and testbench
=======================================

# multiplier_shift_add

Sequential shift-add multiply-accumulate computing n = q·d + r, the inverse of the restoring divider. It rebuilds a dividend from a quotient, divisor and remainder, for divider self-check loops and for datapaths that re-scale a quotient. It processes one quotient bit per clock, LSB first, behind a start/busy/done handshake. Operand widths match the divider: quotient WN bits, divisor and remainder WD bits.

## Interface
- WN, 8, width of quotient q_in; iteration count
- WD, 6, width of divisor d_in and remainder r_in
- clk  input  1  system synchronous clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- q_in  input  WN  quotient, unsigned
- d_in  input  WD  divisor, unsigned
- r_in  input  WD  remainder, unsigned
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; n_out valid
- n_out  output  WN+WD  result q·d + r, unsigned, held until next done
- rem_err  output  1  r_in ≥ d_in for the latched operands (see Configuration)

## Operation
- States: IDLE, RUN. Reset enters IDLE.
- IDLE with start=1 at an edge:
  - latch q_reg←q_in, d_sh←d_in zero-extended to WN+WD, acc←r_in zero-extended, cnt←0.
  - go to RUN.
- IDLE with start=0: hold all registers.
- RUN, each edge:
  - if q_reg[0], acc←acc+d_sh.
  - d_sh←d_sh<<1; q_reg←q_reg>>1; cnt←cnt+1.
- RUN exit: on the edge where cnt=WN-1, after the final accumulate:
  - n_out←final acc; done←1; state←IDLE.
- Width rule: acc is WN+WD bits. The maximum (2^WN−1)(2^WD−1)+(2^WD−1) = (2^WD−1)·2^WN < 2^(WN+WD), so overflow is impossible and there is no carry-out.
- d_in=0 or q_in=0: still takes WN iterations; n_out=r_in.
- start while busy=1: ignored; operands are not re-latched.
- start in the cycle done=1: accepted, because the state is IDLE.
- Inputs are only sampled on the start edge. Later changes to q_in, d_in or r_in do not affect the operation in flight.

## Timing
- Reset values:
  - busy=0, done=0, n_out=0, rem_err=0.
  - internal acc, d_sh, q_reg, cnt = 0.
- Asynchronous reset mid-operation aborts immediately. No done is produced, and n_out returns to 0.
- Edge timing, with start sampled at edge E0:
  - busy=1 from after E0 through edge E(WN).
  - done=1 for exactly the cycle following E(WN).
  - n_out updates at E(WN).
- Latency: WN clocks from the start edge to the done pulse (8 for defaults).
- Back-to-back throughput: one result per WN+1 clocks.
- Outputs are all registered, with no combinational path from inputs to outputs.

## Configuration
- MUL_SHIFT_ADD_CHECK_EN defined:
  - at the start edge, rem_err←(r_in ≥ d_in); held until the next start edge.
  - flags operand sets that cannot come from a valid division. d_in=0 always flags.
- Not defined:
  - rem_err is tied to constant 0 and no comparator is built.
  - all other behaviour is identical.

## Test plan
- Reset then idle: rst_n low mid-cycle -> busy=0, done=0, n_out=0, rem_err=0 asynchronously; start=0 for 20 cycles -> no change.
- q=200, d=45, r=30 (WN=8, WD=6) -> done 8 clocks after the start edge, n_out=9030, busy high 8 cycles, rem_err=0.
- Corners:
  - q=255, d=63, r=62 -> n_out=16127.
  - q=0, d=63, r=5 -> n_out=5.
  - q=17, d=0, r=0 -> n_out=0, rem_err=1 when the macro is defined, else 0.
- Handshake:
  - start pulsed during RUN with different operands -> ignored, result unchanged.
  - start asserted in the done cycle -> second operation starts, done 9 clocks after the first done.
- rst_n asserted at iteration 4 of q=200, d=45, r=30 -> no done pulse, n_out=0; the next start with the same operands gives 9030.
- r=50, d=45 with macro defined -> rem_err=1 from the start edge, n_out=q·45+50.

Source files
------------

// File: rtl/multiplier_shift_add.sv
// Sequential shift-add multiply-accumulate: n = q*d + r, one quotient bit per clock.
// Optional operand check (rem_err) built when MUL_SHIFT_ADD_CHECK_EN is defined.
module multiplier_shift_add #(
   parameter int WN = 8,
   parameter int WD = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WN-1:0]    q_in,
   input  logic [WD-1:0]    d_in,
   input  logic [WD-1:0]    r_in,
   output logic             busy,
   output logic             done,
   output logic [WN+WD-1:0] n_out,
   output logic             rem_err
);

   localparam int WR = WN + WD;
   localparam int CW = $clog2(WN + 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [WN-1:0] q_reg;
   logic [WR-1:0] d_sh;
   logic [WR-1:0] acc;
   logic [WR-1:0] acc_sum;
   logic [CW-1:0] cnt;
   logic          last;
   logic          take;

   assign take    = (state == IDLE) && start;
   assign last    = (cnt == CW'(WN - 1));
   assign acc_sum = acc + (q_reg[0] ? d_sh : '0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic: run exactly WN iterations per request
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) state_nx = RUN;
         RUN:  if (last)  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output decode: busy follows the registered state
   always_comb begin
      busy = 1'b0;
      unique case (state)
         IDLE: busy = 1'b0;
         RUN:  busy = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   // Datapath: latch operands on start, then shift-add LSB first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg <= '0;
         d_sh  <= '0;
         acc   <= '0;
         cnt   <= '0;
         n_out <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (take) begin
            q_reg <= q_in;
            d_sh  <= WR'(d_in);
            acc   <= WR'(r_in);
            cnt   <= '0;
         end else if (state == RUN) begin
            acc   <= acc_sum;
            d_sh  <= d_sh << 1;
            q_reg <= q_reg >> 1;
            cnt   <= cnt + CW'(1);
            if (last) begin
               n_out <= acc_sum;
               done  <= 1'b1;
            end
         end
      end
   end

`ifdef MUL_SHIFT_ADD_CHECK_EN
   // Flag operand sets that no valid division could have produced
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    rem_err <= 1'b0;
      else if (take) rem_err <= (r_in >= d_in);
   end
`else
   assign rem_err = 1'b0;
`endif

endmodule

// File: tb/tb_multiplier_shift_add.sv
// Directed self-checking bench for multiplier_shift_add (WN=8, WD=6).
// Expected results are hand-computed constants.
module tb_multiplier_shift_add;

   localparam int WN = 8;
   localparam int WD = 6;

`ifdef MUL_SHIFT_ADD_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WN-1:0]    q_in;
   logic [WD-1:0]    d_in;
   logic [WD-1:0]    r_in;
   logic             busy;
   logic             done;
   logic [WN+WD-1:0] n_out;
   logic             rem_err;

   int checks = 0;
   int errors = 0;

   multiplier_shift_add #(.WN(WN), .WD(WD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .q_in    (q_in),
      .d_in    (d_in),
      .r_in    (r_in),
      .busy    (busy),
      .done    (done),
      .n_out   (n_out),
      .rem_err (rem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present operands and let the next edge (E0) sample start
   task automatic start_op(input int q, input int d, input int r);
      q_in  = WN'(q);
      d_in  = WD'(d);
      r_in  = WD'(r);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      q_in  = '1;
      d_in  = '1;
      r_in  = '1;
      chk("busy_after_start", int'(busy), 1);
      chk("done_after_start", int'(done), 0);
   endtask

   // Walk edges E1..E(WN); optionally poke start mid-run with other operands
   task automatic wait_done(input string tag, input int exp_n,
                            input int exp_err, input bit poke);
      for (int i = 1; i < WN; i++) begin
         if (poke && i == 3) begin
            q_in  = 8'd255;
            d_in  = 6'd63;
            r_in  = 6'd63;
            start = 1'b1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done !== 1'b0 || busy !== 1'b1) begin
            chk({tag, "_early"}, int'({busy, done}), 2);
         end
      end
      @(posedge clk);
      #1;
      chk({tag, "_done"}, int'(done), 1);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_n"}, int'(n_out), exp_n);
      chk({tag, "_err"}, int'(rem_err), exp_err);
   endtask

   task automatic done_drop(input string tag);
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, int'(done), 0);
   endtask

   initial begin
      start = 1'b0;
      q_in  = '0;
      d_in  = '0;
      r_in  = '0;
      rst_n = 1'b0;
      #3;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_n_out", int'(n_out), 0);
      chk("rst_err", int'(rem_err), 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Idle hold: nothing moves with start low
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (busy !== 1'b0 || done !== 1'b0 || n_out !== '0)
            chk("idle_hold", int'({busy, done}), 0);
      end
      chk("idle_n_out", int'(n_out), 0);

      // Main vector
      start_op(200, 45, 30);
      wait_done("basic", 9030, 0, 1'b0);
      done_drop("basic");

      // Corners
      start_op(255, 63, 62);
      wait_done("max", 16127, 0, 1'b0);
      done_drop("max");
      start_op(0, 63, 5);
      wait_done("q0", 5, 0, 1'b0);
      done_drop("q0");
      start_op(17, 0, 0);
      wait_done("d0", 0, int'(CHK), 1'b0);
      done_drop("d0");
      chk("err_held", int'(rem_err), int'(CHK));

      // start during RUN is ignored
      start_op(10, 3, 1);
      wait_done("poke", 31, 0, 1'b1);
      done_drop("poke");

      // start in the done cycle: second done WN+1 clocks later
      start_op(200, 45, 30);
      wait_done("b2b_a", 9030, 0, 1'b0);
      start_op(100, 20, 7);
      wait_done("b2b_b", 2007, 0, 1'b0);
      done_drop("b2b_b");

      // Asynchronous abort at iteration 4
      start_op(200, 45, 30);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_n_out", int'(n_out), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done !== 1'b0 || busy !== 1'b0)
            chk("abort_quiet", int'({busy, done}), 0);
      end
      chk("abort_n_hold", int'(n_out), 0);
      start_op(200, 45, 30);
      wait_done("rerun", 9030, 0, 1'b0);
      done_drop("rerun");

      // Remainder not below divisor
      start_op(3, 45, 50);
      chk("rem_err_early", int'(rem_err), int'(CHK));
      wait_done("remerr", 185, int'(CHK), 1'b0);
      done_drop("remerr");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
